// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized line, mid-bit sampling, 8 data bits
// LSB first, optional parity, valid/ready byte output with error pulses.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic       rx_clk,
  input  logic       rx_rst_n,
  input  logic       rx_en,
  input  logic       rx_i,
  output logic [7:0] rx_o_data,
  output logic       rx_o_data_valid,
  input  logic       rx_i_ready,
  output logic       rx_o_frame_err,
  output logic       rx_o_parity_err,
  output logic       rx_o_overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic ODD = (PARITY_ODD != 0);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_WAIT  = 3'd5;

  logic          sync1_q, sync2_q, rx_s;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          pbad_q, pbad_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          fe_q, fe_d;
  logic          pe_q, pe_d;
  logic          ov_q, ov_d;
  logic          deliver;

  assign rx_s = sync2_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    pbad_d  = pbad_q;
    data_d  = data_q;
    valid_d = valid_q;
    fe_d    = 1'b0;
    pe_d    = 1'b0;
    ov_d    = 1'b0;
    deliver = 1'b0;

    if (valid_q && rx_i_ready) valid_d = 1'b0;

    if (!rx_en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s) begin
            state_d = S_START;
            cnt_d   = '0;
            bit_d   = '0;
            pbad_d  = 1'b0;
          end
        end
        S_START: begin
          if (cnt_q == HALF) begin
            cnt_d   = '0;
            state_d = rx_s ? S_IDLE : S_DATA;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_DATA: begin
          if (cnt_q == FULL) begin
            cnt_d   = '0;
            shreg_d = {rx_s, shreg_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7)
              state_d = (PARITY_EN != 0) ? S_PAR : S_STOP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_PAR: begin
          if (cnt_q == FULL) begin
            cnt_d   = '0;
            pbad_d  = (^{shreg_q, rx_s}) ^ ODD;
            state_d = S_STOP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_STOP: begin
          if (cnt_q == FULL) begin
            cnt_d = '0;
            // a low stop bit outranks any parity complaint
            if (!rx_s) begin
              fe_d    = 1'b1;
              state_d = S_WAIT;
            end else begin
              state_d = S_IDLE;
              if (pbad_q) pe_d = 1'b1;
              else        deliver = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_WAIT: begin
          if (rx_s) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (deliver) begin
      if (valid_q && !rx_i_ready) begin
        ov_d = 1'b1;
      end else begin
        data_d  = shreg_q;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      pbad_q  <= 1'b0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      pbad_q  <= pbad_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      pe_q    <= pe_d;
      ov_q    <= ov_d;
    end
  end

  assign rx_o_data       = data_q;
  assign rx_o_data_valid = valid_q;
  assign rx_o_frame_err  = fe_q;
  assign rx_o_parity_err = pe_q;
  assign rx_o_overrun    = ov_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: an 8N1 instance and an even-parity instance driven
// with serial frames; consumed bytes and error pulses checked vs a byte model.
module tb_uart_rx;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en_a = 1'b1, en_b = 1'b1;
  logic rx_a = 1'b1, rx_b = 1'b1;
  logic rdy_a = 1'b0, rdy_b = 1'b0;
  logic [7:0] da, db;
  logic va, vb, fea, feb, pea, peb, ova, ovb;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] got_a[$];
  logic [7:0] got_b[$];
  int fe_a = 0, pe_a = 0, ov_a = 0;
  int fe_b = 0, pe_b = 0, ov_b = 0;

  uart_rx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0)) u_a (
    .rx_clk(clk), .rx_rst_n(rst_n), .rx_en(en_a), .rx_i(rx_a),
    .rx_o_data(da), .rx_o_data_valid(va), .rx_i_ready(rdy_a),
    .rx_o_frame_err(fea), .rx_o_parity_err(pea), .rx_o_overrun(ova)
  );

  uart_rx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)) u_b (
    .rx_clk(clk), .rx_rst_n(rst_n), .rx_en(en_b), .rx_i(rx_b),
    .rx_o_data(db), .rx_o_data_valid(vb), .rx_i_ready(rdy_b),
    .rx_o_frame_err(feb), .rx_o_parity_err(peb), .rx_o_overrun(ovb)
  );

  always #5 clk = ~clk;

  // handshakes and pulses seen by the next rising edge
  always @(negedge clk) begin
    if (va && rdy_a) got_a.push_back(da);
    if (vb && rdy_b) got_b.push_back(db);
    if (fea) fe_a++;
    if (pea) pe_a++;
    if (ova) ov_a++;
    if (feb) fe_b++;
    if (peb) pe_b++;
    if (ovb) ov_b++;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic line(input int d, input logic v, input int n);
    if (d == 0) rx_a = v;
    else        rx_b = v;
    step(n);
  endtask

  task automatic send(input int d, input logic [7:0] b,
                      input logic par_ok, input logic stop);
    line(d, 1'b0, CPB);
    for (int i = 0; i < 8; i++) line(d, b[i], CPB);
    if (d == 1) line(d, (^b) ^ ~par_ok, CPB);
    line(d, stop, CPB);
  endtask

  initial begin : main
    int n0, f0, p0, o0, nfe;
    logic [7:0] b, r;
    logic [7:0] exp_q[$];

    step(3);
    check("rst_data", 32'(da), 0);
    check("rst_valid", 32'(va), 0);
    check("rst_errs", 32'({fea, pea, ova}), 0);
    check("rst_b", 32'({vb, feb, peb, ovb}), 0);
    rst_n = 1'b1;
    step(3);

    // hold-until-ready
    rdy_a = 1'b0;
    n0 = got_a.size();
    send(0, 8'hAA, 1'b1, 1'b1);
    step(4);
    check("aa_valid", 32'(va), 1);
    check("aa_data", 32'(da), 32'hAA);
    step(20);
    check("aa_hold", 32'(va), 1);
    rdy_a = 1'b1;
    step(1);
    rdy_a = 1'b0;
    check("aa_consumed", 32'(va), 0);
    check("aa_count", 32'(got_a.size() - n0), 1);
    if (got_a.size() > n0) check("aa_got", 32'(got_a[n0]), 32'hAA);

    // back to back
    rdy_a = 1'b1;
    n0 = got_a.size(); f0 = fe_a; p0 = pe_a; o0 = ov_a;
    send(0, 8'h19, 1'b1, 1'b1);
    send(0, 8'hA5, 1'b1, 1'b1);
    step(4);
    check("b2b_count", 32'(got_a.size() - n0), 2);
    if (got_a.size() >= n0 + 2) begin
      check("b2b_first", 32'(got_a[n0]), 32'h19);
      check("b2b_second", 32'(got_a[n0+1]), 32'hA5);
    end
    check("b2b_errs", 32'((fe_a - f0) + (pe_a - p0) + (ov_a - o0)), 0);

    // framing error with stuck-low line
    n0 = got_a.size(); f0 = fe_a;
    send(0, 8'h3C, 1'b1, 1'b0);
    line(0, 1'b0, 40);
    check("fe_pulse", 32'(fe_a - f0), 1);
    check("fe_nobyte", 32'(got_a.size() - n0), 0);
    line(0, 1'b1, CPB);
    send(0, 8'h3C, 1'b1, 1'b1);
    step(4);
    check("fe_recover_cnt", 32'(got_a.size() - n0), 1);
    if (got_a.size() > n0) check("fe_recover", 32'(got_a[n0]), 32'h3C);
    check("fe_once", 32'(fe_a - f0), 1);

    // start-bit glitch
    n0 = got_a.size(); f0 = fe_a; p0 = pe_a; o0 = ov_a;
    line(0, 1'b0, 4);
    line(0, 1'b1, 2 * CPB);
    check("glitch_nobyte", 32'(got_a.size() - n0), 0);
    check("glitch_errs", 32'((fe_a - f0) + (pe_a - p0) + (ov_a - o0)), 0);
    r = 8'($urandom);
    send(0, r, 1'b1, 1'b1);
    step(4);
    check("glitch_after_cnt", 32'(got_a.size() - n0), 1);
    if (got_a.size() > n0) check("glitch_after", 32'(got_a[n0]), 32'(r));

    // overrun
    rdy_a = 1'b0;
    n0 = got_a.size(); o0 = ov_a;
    send(0, 8'h11, 1'b1, 1'b1);
    send(0, 8'h22, 1'b1, 1'b1);
    step(4);
    check("ovr_data", 32'(da), 32'h11);
    check("ovr_valid", 32'(va), 1);
    check("ovr_pulse", 32'(ov_a - o0), 1);
    rdy_a = 1'b1;
    step(2);
    check("ovr_count", 32'(got_a.size() - n0), 1);
    if (got_a.size() > n0) check("ovr_got", 32'(got_a[n0]), 32'h11);

    // randomized frames with occasional bad stop bits
    n0 = got_a.size(); f0 = fe_a; nfe = 0;
    for (int i = 0; i < 24; i++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        send(0, b, 1'b1, 1'b0);
        line(0, 1'b0, $urandom_range(0, 30));
        line(0, 1'b1, CPB + $urandom_range(0, 8));
        nfe++;
      end else begin
        send(0, b, 1'b1, 1'b1);
        exp_q.push_back(b);
        step($urandom_range(0, CPB));
      end
    end
    step(CPB);
    check("rnd_count", 32'(got_a.size() - n0), 32'(exp_q.size()));
    check("rnd_fe", 32'(fe_a - f0), 32'(nfe));
    for (int i = 0; i < exp_q.size(); i++)
      if (n0 + i < got_a.size())
        check("rnd_byte", 32'(got_a[n0+i]), 32'(exp_q[i]));

    // parity instance: bad parity
    rdy_b = 1'b1;
    n0 = got_b.size(); p0 = pe_b; f0 = fe_b;
    send(1, 8'h07, 1'b0, 1'b1);
    step(4);
    check("par_pulse", 32'(pe_b - p0), 1);
    check("par_nobyte", 32'(got_b.size() - n0), 0);
    check("par_nofe", 32'(fe_b - f0), 0);
    send(1, 8'h07, 1'b1, 1'b1);
    step(4);
    check("par_good_cnt", 32'(got_b.size() - n0), 1);
    if (got_b.size() > n0) check("par_good", 32'(got_b[n0]), 32'h07);

    // disable mid-frame
    n0 = got_b.size(); p0 = pe_b; f0 = fe_b;
    line(1, 1'b0, CPB);
    line(1, 1'b1, CPB);
    line(1, 1'b0, CPB);
    line(1, 1'b1, CPB / 2);
    en_b = 1'b0;
    step(2 * CPB);
    en_b = 1'b1;
    step(CPB);
    check("dis_nobyte", 32'(got_b.size() - n0), 0);
    check("dis_errs", 32'((pe_b - p0) + (fe_b - f0)), 0);
    send(1, 8'h55, 1'b1, 1'b1);
    step(4);
    check("dis_next_cnt", 32'(got_b.size() - n0), 1);
    if (got_b.size() > n0) check("dis_next", 32'(got_b[n0]), 32'h55);

    // async reset mid-frame drops a pending byte
    rdy_b = 1'b0;
    send(1, 8'h99, 1'b1, 1'b1);
    step(4);
    check("rr_pending", 32'({vb, db}), 32'h199);
    line(1, 1'b0, CPB);
    line(1, 1'b1, CPB / 2);
    rst_n = 1'b0;
    #1;
    check("rr_async", 32'({vb, db}), 0);
    step(2);
    rst_n = 1'b1;
    step(CPB);
    rdy_b = 1'b1;
    n0 = got_b.size();
    send(1, 8'h55, 1'b1, 1'b1);
    step(4);
    check("rr_next_cnt", 32'(got_b.size() - n0), 1);
    if (got_b.size() > n0) check("rr_next", 32'(got_b[n0]), 32'h55);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
